// File: rtl/psum_requant_buffer_pkg.sv
// psum_requant_buffer_pkg: default widths and saturation bounds for the requantizer
package psum_requant_buffer_pkg;
  localparam int PSUM_BW_DEF = 20;
  localparam int OUT_BW_DEF = 8;
  localparam int SHIFT_BW_DEF = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  function automatic int sat_max(int bw);
    return (1 << (bw - 1)) - 1;
  endfunction
  function automatic int sat_min(int bw);
    return -(1 << (bw - 1));
  endfunction
endpackage

// File: rtl/psum_requant_buffer_sync_fifo.sv
// sync_fifo: registered-storage FIFO, no fall-through, head always on rd_data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rd;
  assign rd = rd_en & !empty;
  assign rd_data = mem[rp];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd);
    end
endmodule

// File: rtl/psum_requant_buffer.sv
// psum_requant_buffer: round/shift/saturate PE row sums, buffer results, credit-throttle upstream
module psum_requant_buffer
  import psum_requant_buffer_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = PSUM_BW_DEF,
  parameter int OUT_BW = OUT_BW_DEF,
  parameter int SHIFT_BW = SHIFT_BW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PARTIAL_SUM_BW-1:0] psum,
  input  logic                      psum_valid,
  output logic                      in_ready,
  input  logic [SHIFT_BW-1:0]       shift,
  output logic [OUT_BW-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sat_flag,
  output logic                      ovf_err,
  input  logic                      err_clr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [PARTIAL_SUM_BW:0] SMAX = (PARTIAL_SUM_BW + 1)'(sat_max(OUT_BW));
  localparam logic signed [PARTIAL_SUM_BW:0] SMIN = (PARTIAL_SUM_BW + 1)'(sat_min(OUT_BW));
  logic s1_v, s2_v, fifo_empty, fifo_full, clip;
  logic [CW-1:0] fifo_count;
  logic [CW:0] credit;
  logic [SHIFT_BW-1:0] sh;
  logic signed [PARTIAL_SUM_BW:0] ext, half, rnd, s1_r;
  logic [OUT_BW-1:0] sat_d, s2_d;
  // credit counts every result already committed to a FIFO slot, including in-flight ones
  assign credit = {1'b0, fifo_count} + (CW + 1)'(s1_v) + (CW + 1)'(s2_v);
  assign in_ready = !fifo_full && credit < (CW + 1)'(FIFO_DEPTH);
  assign out_valid = !fifo_empty;
  always_comb begin
    sh = int'(shift) >= PARTIAL_SUM_BW ? SHIFT_BW'(PARTIAL_SUM_BW - 1) : shift;
    ext = {psum[PARTIAL_SUM_BW-1], psum};
    half = (PARTIAL_SUM_BW + 1)'(1) << (sh - SHIFT_BW'(1));
    rnd = sh == '0 ? ext : (ext + half) >>> sh;
    clip = s1_r > SMAX || s1_r < SMIN;
    sat_d = s1_r > SMAX ? SMAX[OUT_BW-1:0] : s1_r < SMIN ? SMIN[OUT_BW-1:0] : s1_r[OUT_BW-1:0];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_r <= '0;
      s2_d <= '0;
      sat_flag <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      s1_v <= psum_valid & in_ready;
      s2_v <= s1_v;
      s1_r <= rnd;
      s2_d <= sat_d;
      sat_flag <= (s1_v & clip) | (sat_flag & !err_clr);
      ovf_err <= (psum_valid & !in_ready) | (ovf_err & !err_clr);
    end
  sync_fifo #(.WIDTH(OUT_BW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .wr_en(s2_v),
    .wr_data(s2_d),
    .rd_en(out_valid & out_ready),
    .rd_data(out_data),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule
